cam_cfg_sequencer: RTL and testbench
====================================

// Module: cam_cfg_sequencer
// PURPOSE
//  Upstream of the SCCB/IIC register driver. After reset it walks a register table
//  (camera_cfg_rom) and issues one write transaction per entry. Write format is
//  device 0x42, then reg addr, then data. Handles the driver handshake, retries,
//  timeouts and inline delays. Raises done (or error) when the table is finished.
// PARAMETERS
//  POWERUP_CYCLES   2000  clk cycles to wait after reset/start before first entry
//  GAP_CYCLES       16    idle clk cycles between transactions (driver wr_en low)
//  DELAY_UNIT       200   clk cycles per unit of a delay entry's data byte
//  TIMEOUT_CYCLES   1024  max cycles waiting on the driver per transaction
//  MAX_RETRY        3     re-issues of a failed entry before error
//  ACK_FAIL_LEVEL   1     iic_ack level that means the transaction was NACKed
// PORTS
//  clk            in   1  clock, same domain as the IIC driver
//  rst            in   1  asynchronous reset, active-low
//  start          in   1  level; rising edge (re)starts the sequence from index 0
//  busy           out  1  high from start until done/error
//  done           out  1  sticky; table completed, cleared by next start
//  error          out  1  sticky; retries exhausted, cleared by next start
//  err_index      out  8  table index of the failing entry (valid when error)
//  cfg_index      out  8  current table index
//  iic_wr_en      out  1  one-cycle write request pulse to driver
//  iic_rd_en      out  1  constant 0
//  iic_addr       out  8  register address, stable from ISSUE until WAIT_DONE exits
//  iic_data       out  8  register data, stable from ISSUE until WAIT_DONE exits
//  iic_work_done  in   1  driver done flag: cleared at transaction begin, set at stop
//  iic_ack        in   1  driver ack summary, sampled when work_done rises
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, index 0, retry count 0, counters 0.
//  The FSM leaves reset through POWER_WAIT, so configuration starts without start.
//  Only a start rising edge re-enters POWER_WAIT after done/error.
//  States:
//   IDLE:       a start rising edge goes to POWER_WAIT. Clears done, error, index and retry.
//   POWER_WAIT: count POWERUP_CYCLES, then go to FETCH.
//   FETCH:      read rom[index] as {addr,data}. Combinational ROM, 1 cycle.
//               addr=0xFF,data=0xFF: end of table, go to FINISH.
//               addr=0xFE: delay entry, go to DELAY.
//               otherwise go to ISSUE.
//   DELAY:      wait data*DELAY_UNIT cycles (data=0 means 0 cycles), then index+1 and FETCH.
//   ISSUE:      iic_wr_en=1 for exactly this cycle, then go to WAIT_START.
//   WAIT_START: wait for iic_work_done==0, i.e. the driver has begun.
//   WAIT_DONE:  wait for iic_work_done==1 and sample iic_ack.
//               iic_ack!=ACK_FAIL_LEVEL: success; clear retry, index+1, go to GAP.
//               Otherwise it is a failure.
//   GAP:        wait GAP_CYCLES, then FETCH. iic_wr_en must stay low here, because the
//               driver restarts whenever wr_en is high at its idle state.
//   FINISH:     done=1, busy=0, then IDLE.
//  Timeouts: the timeout counter runs across WAIT_START+WAIT_DONE. Reaching
//   TIMEOUT_CYCLES counts as a failure.
//  Failure: if retry<MAX_RETRY then retry+1 and go to GAP (same index re-issued).
//   Otherwise error=1, err_index=index, busy=0, go to IDLE.
//  Boundaries:
//   Index is 8 bits; if it wraps past 255 without a terminator, end as FINISH.
//   A start edge while busy is ignored.
//   Async reset mid-transaction drops wr_en at once and restarts via POWER_WAIT.
//   The driver shares rst, so it also returns to idle.
//   All counters saturate-compare with >=; there is no wrap on overflow.
// STRUCTURE
//  Package cam_cfg_pkg: state encoding (localparams), END_MARK=16'hFFFF,
//   DELAY_MARK=8'hFE, SCCB device IDs 8'h42/8'h43.
//  Sub-module camera_cfg_rom: input [7:0] index, output [15:0] {addr,data}; table
//   contents live there only. The sequencer itself holds the FSM, one shared
//   16-bit cycle counter, the retry counter and the start edge detector.
// TESTING
//  Bench uses a behavioural driver model. It clears work_done 3 cycles after wr_en,
//   sets it 40 cycles later, and its ack response is programmable. It is paired with a
//   test ROM {0x12,0x80},{0xFE,0x02},{0x11,0x01},{0xFF,0xFF}.
//  1 Reset release, all ACK ok:
//     no wr_en for 2000 cycles; then 2 wr_en pulses with addr/data 0x12/0x80 and 0x11/0x01;
//     done=1, busy=0, error=0.
//  2 Delay entry: gap between the 1st transaction completing and the 2nd wr_en is
//     >= 16+400 cycles.
//  3 Entry 0 NACKed twice, then ok: 3 wr_en pulses with 0x12/0x80; sequence still ends
//     with done=1.
//  4 Entry 2 NACKed always: 4 pulses with 0x11/0x01, then error=1, err_index=2,
//     done=0, busy=0.
//  5 Driver model never clears work_done: after 1024 cycles a retry is issued; after
//     4 attempts error=1.
//  6 Reset pulse during WAIT_DONE: wr_en=0 immediately; after release the sequence
//     restarts from index 0 after 2000 cycles. A start edge after done reruns the table.

Source files
------------

// File: rtl/cam_cfg_sequencer_pkg.sv
// Shared definitions for the camera configuration sequencer.
// Contents:
//   state_e      - sequencer FSM state encoding (also exported for debug)
//   END_MARK     - {addr,data} word that terminates the register table
//   DELAY_MARK   - address byte that marks an inline delay entry
//   SCCB_ID_*    - SCCB device IDs of the camera (write / read)
//   rom_word     - helper that packs one table entry as {addr,data}
package cam_cfg_pkg;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_POWER_WAIT = 4'd1,
        ST_FETCH      = 4'd2,
        ST_DELAY      = 4'd3,
        ST_ISSUE      = 4'd4,
        ST_WAIT_START = 4'd5,
        ST_WAIT_DONE  = 4'd6,
        ST_GAP        = 4'd7,
        ST_FINISH     = 4'd8
    } state_e;

    localparam logic [15:0] END_MARK   = 16'hFFFF;
    localparam logic [7:0]  DELAY_MARK = 8'hFE;
    localparam logic [7:0]  SCCB_ID_WR = 8'h42;
    localparam logic [7:0]  SCCB_ID_RD = 8'h43;

    function automatic logic [15:0] rom_word(input logic [7:0] addr, input logic [7:0] data);
        return {addr, data};
    endfunction

endpackage

// File: rtl/cam_cfg_sequencer_if.sv
// Bus between the configuration sequencer and the SCCB/IIC register driver.
// Signals:
//   iic_wr_en      master->slave  one-cycle write request pulse
//   iic_rd_en      master->slave  read request (the sequencer never reads)
//   iic_addr       master->slave  register address
//   iic_data       master->slave  register data
//   iic_work_done  slave->master  driver done flag
//   iic_ack        slave->master  driver ack summary
//
// Handshake: the master raises iic_wr_en for exactly one cycle with iic_addr and
// iic_data already valid, and holds addr/data until the transaction is closed.
// The slave acknowledges acceptance by dropping iic_work_done, and reports
// completion by raising iic_work_done again; iic_ack is valid in the cycle in
// which iic_work_done is seen high after having been low. iic_wr_en is never
// high while a transaction is outstanding or during the inter-transaction gap.
interface cam_cfg_sequencer_if;

    logic       iic_wr_en;
    logic       iic_rd_en;
    logic [7:0] iic_addr;
    logic [7:0] iic_data;
    logic       iic_work_done;
    logic       iic_ack;

    modport master (
        output iic_wr_en, iic_rd_en, iic_addr, iic_data,
        input  iic_work_done, iic_ack
    );

    modport slave (
        input  iic_wr_en, iic_rd_en, iic_addr, iic_data,
        output iic_work_done, iic_ack
    );

endinterface

// File: rtl/cam_cfg_sequencer_rom.sv
// Camera register table, combinational lookup.
// Ports:
//   index  in   8  table index
//   entry  out  16 {register address, register data}
// Entries with address DELAY_MARK are delays of data*DELAY_UNIT cycles; the
// table ends at END_MARK. Every index past the table reads as END_MARK so a
// runaway index terminates cleanly.
module camera_cfg_rom
    import cam_cfg_pkg::*;
(
    input  logic [7:0]  index,
    output logic [15:0] entry
);

    always_comb begin
        entry = END_MARK;
        case (index)
            8'd0:    entry = rom_word(8'h12, 8'h80);   // COM7: soft reset
            8'd1:    entry = rom_word(DELAY_MARK, 8'h02); // settle after soft reset
            8'd2:    entry = rom_word(8'h11, 8'h01);   // CLKRC: prescaler
            8'd3:    entry = END_MARK;
            default: entry = END_MARK;
        endcase
    end

endmodule

// File: rtl/cam_cfg_sequencer.sv
// Camera configuration sequencer: walks camera_cfg_rom after reset (or a start
// rising edge) and issues one register write per entry to the SCCB/IIC driver,
// with retries, per-transaction timeout and inline delays.
// Ports:
//   clk          in   1  clock (driver domain)
//   rst          in   1  asynchronous reset, active-low
//   start        in   1  rising edge restarts the table from index 0 when idle
//   busy         out  1  sequence in progress
//   done         out  1  sticky: table completed
//   error        out  1  sticky: retries exhausted
//   err_index    out  8  index of the failing entry
//   cfg_index    out  8  current table index
//   dbg_state_o  out  4  current FSM state
//   iic          master modport of cam_cfg_sequencer_if
module cam_cfg_sequencer
    import cam_cfg_pkg::*;
#(
    parameter int   POWERUP_CYCLES = 2000,
    parameter int   GAP_CYCLES     = 16,
    parameter int   DELAY_UNIT     = 200,
    parameter int   TIMEOUT_CYCLES = 1024,
    parameter int   MAX_RETRY      = 3,
    parameter logic ACK_FAIL_LEVEL = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [7:0]             err_index,
    output logic [7:0]             cfg_index,
    output state_e                 dbg_state_o,
    cam_cfg_sequencer_if.master    iic
);

    // Terminal counts: a phase that must last N cycles ends when the counter,
    // started at 0, reaches N-1.
    localparam logic [15:0] PWR_LAST  = 16'(POWERUP_CYCLES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

    state_e      state_q;
    logic        boot_q;        // forces the first pass after reset without start
    logic        start_q;
    logic [15:0] cnt_q;         // shared by power-up, delay, gap and timeout
    logic [15:0] delay_len_q;
    logic [3:0]  retry_q;
    logic [7:0]  index_q;
    logic        busy_q;
    logic        done_q;
    logic        error_q;
    logic [7:0]  err_index_q;
    logic        wr_en_q;
    logic [7:0]  addr_q;
    logic [7:0]  data_q;

    logic [15:0] rom_entry;
    logic [7:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        start_rise;
    logic        in_wait;
    logic        xfer_seen;
    logic        xfer_ok;
    logic        xfer_fail;
    logic        last_index;

    camera_cfg_rom u_rom (
        .index (index_q),
        .entry (rom_entry)
    );

    assign rom_addr   = rom_entry[15:8];
    assign rom_data   = rom_entry[7:0];
    assign start_rise = start & ~start_q;
    assign last_index = (index_q == 8'hFF);

    // A completion is only meaningful once the driver has dropped work_done,
    // so it is accepted in WAIT_DONE only. The timeout covers both wait states.
    always_comb begin
        in_wait   = (state_q == ST_WAIT_START) || (state_q == ST_WAIT_DONE);
        xfer_seen = (state_q == ST_WAIT_DONE) && iic.iic_work_done;
        xfer_ok   = xfer_seen && (iic.iic_ack != ACK_FAIL_LEVEL);
        xfer_fail = in_wait && ((xfer_seen && !xfer_ok) || (!xfer_seen && cnt_q >= TMO_LAST));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            boot_q      <= 1'b1;
            start_q     <= 1'b0;
            cnt_q       <= '0;
            delay_len_q <= '0;
            retry_q     <= '0;
            index_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
        end else begin
            start_q <= start;
            wr_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (boot_q || start_rise) begin
                        boot_q      <= 1'b0;
                        done_q      <= 1'b0;
                        error_q     <= 1'b0;
                        err_index_q <= '0;
                        index_q     <= '0;
                        retry_q     <= '0;
                        cnt_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_POWER_WAIT;
                    end
                end
                ST_POWER_WAIT: begin
                    if (cnt_q >= PWR_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_FETCH;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_FETCH: begin
                    cnt_q <= '0;
                    if (rom_entry == END_MARK) begin
                        state_q <= ST_FINISH;
                    end else if (rom_addr == DELAY_MARK) begin
                        delay_len_q <= 16'(rom_data * DELAY_UNIT);
                        state_q     <= ST_DELAY;
                    end else begin
                        addr_q  <= rom_addr;
                        data_q  <= rom_data;
                        wr_en_q <= 1'b1;     // high for the ISSUE cycle only
                        state_q <= ST_ISSUE;
                    end
                end
                ST_DELAY: begin
                    if (cnt_q >= delay_len_q) begin
                        cnt_q <= '0;
                        if (last_index) begin
                            state_q <= ST_FINISH;
                        end else begin
                            index_q <= index_q + 8'd1;
                            state_q <= ST_FETCH;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= ST_WAIT_START;
                end
                ST_WAIT_START, ST_WAIT_DONE: begin
                    if (xfer_ok) begin
                        retry_q <= '0;
                        cnt_q   <= '0;
                        if (last_index) begin
                            state_q <= ST_FINISH;
                        end else begin
                            index_q <= index_q + 8'd1;
                            state_q <= ST_GAP;
                        end
                    end else if (xfer_fail) begin
                        cnt_q <= '0;
                        if (retry_q < RETRY_MAX) begin
                            retry_q <= retry_q + 4'd1;
                            state_q <= ST_GAP;   // same index is fetched again
                        end else begin
                            error_q     <= 1'b1;
                            err_index_q <= index_q;
                            busy_q      <= 1'b0;
                            state_q     <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                        if (state_q == ST_WAIT_START && !iic.iic_work_done) begin
                            state_q <= ST_WAIT_DONE;
                        end
                    end
                end
                ST_GAP: begin
                    if (cnt_q >= GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_FETCH;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                ST_FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign err_index     = err_index_q;
    assign cfg_index     = index_q;
    assign dbg_state_o   = state_q;
    assign iic.iic_wr_en = wr_en_q;
    assign iic.iic_rd_en = 1'b0;
    assign iic.iic_addr  = addr_q;
    assign iic.iic_data  = data_q;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
module tb_cam_cfg_sequencer;
    import cam_cfg_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic start;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       busy, done, error;
    logic [7:0] err_index, cfg_index;
    state_e     dbg_state;

    cam_cfg_sequencer_if iic();

    cam_cfg_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .err_index   (err_index),
        .cfg_index   (cfg_index),
        .dbg_state_o (dbg_state),
        .iic         (iic)
    );

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    int          pulses   = 0;
    int          wr_cyc[$];
    int          comp_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural driver model ----------------
    bit   hang_mode = 1'b0;
    int   nack12    = 0;
    bit   nack11    = 1'b0;
    logic drv_active;
    int   drv_cnt;
    int   att12;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            drv_active        <= 1'b0;
            drv_cnt           <= 0;
            att12             <= 0;
            iic.iic_work_done <= 1'b1;
            iic.iic_ack       <= 1'b0;
        end else begin
            if (start) att12 <= 0;
            if (!drv_active) begin
                if (iic.iic_wr_en && !hang_mode) begin
                    drv_active <= 1'b1;
                    drv_cnt    <= 1;
                end
            end else begin
                drv_cnt <= drv_cnt + 1;
                if (drv_cnt == 3) iic.iic_work_done <= 1'b0;
                if (drv_cnt == 43) begin
                    iic.iic_work_done <= 1'b1;
                    drv_active        <= 1'b0;
                    comp_cyc.push_back(cyc);
                    if (iic.iic_addr == 8'h12) begin
                        iic.iic_ack <= (att12 < nack12);
                        att12       <= att12 + 1;
                    end else if (iic.iic_addr == 8'h11) begin
                        iic.iic_ack <= nack11;
                    end else begin
                        iic.iic_ack <= 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- monitor ----------------
    logic prev_wr = 1'b0;
    always @(negedge clk) begin
        if (rst && iic.iic_wr_en) begin
            pulses++;
            wr_cyc.push_back(cyc);
            chk("wr_one_cycle", {31'b0, prev_wr}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wr_unexpected actual=%02h/%02h required=none", iic.iic_addr, iic.iic_data);
            end else begin
                chk("wr_addr_data", {16'b0, iic.iic_addr, iic.iic_data}, {16'b0, exp_q.pop_front()});
            end
        end
        prev_wr = iic.iic_wr_en;
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, input string name);
        int n = 0;
        repeat (3) @(negedge clk);
        while (!(!busy && (done || error)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s_timeout actual=%0d cycles required<%0d", name, n, budget);
        end
    endtask

    // ---------------- stimulus ----------------
    int base;
    int rel;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_wr_en", iic.iic_wr_en, 0);
        chk("rst_rd_en", iic.iic_rd_en, 0);
        chk("rst_cfg_index", cfg_index, 0);
        chk("rst_err_index", err_index, 0);
        chk("rst_state", dbg_state, ST_IDLE);

        // 1/2: boot without start, all ack ok, delay entry
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1101);
        base = pulses;
        rel  = cyc;
        rst  = 1'b1;
        wait_end(6000, "t1");
        chk("t1_done", done, 1);
        chk("t1_busy", busy, 0);
        chk("t1_error", error, 0);
        chk("t1_pulses", pulses - base, 2);
        chk("t1_cfg_index", cfg_index, 3);
        chk("t1_queue_empty", exp_q.size(), 0);
        chk("t1_powerup_min", (wr_cyc[base] - rel) >= 2000, 1);
        chk("t1_powerup_max", (wr_cyc[base] - rel) <= 2010, 1);
        chk("t2_delay_gap", (wr_cyc[base + 1] - comp_cyc[0]) >= 416, 1);

        // 3: entry 0 NACKed twice then ok
        nack12 = 2;
        repeat (3) exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1101);
        base = pulses;
        pulse_start();
        wait_end(8000, "t3");
        chk("t3_done", done, 1);
        chk("t3_error", error, 0);
        chk("t3_pulses", pulses - base, 4);
        chk("t3_queue_empty", exp_q.size(), 0);

        // 4: entry 2 always NACKed
        nack12 = 0;
        nack11 = 1'b1;
        exp_q.push_back(16'h1280);
        repeat (4) exp_q.push_back(16'h1101);
        base = pulses;
        pulse_start();
        wait_end(8000, "t4");
        chk("t4_error", error, 1);
        chk("t4_err_index", err_index, 2);
        chk("t4_done", done, 0);
        chk("t4_busy", busy, 0);
        chk("t4_pulses", pulses - base, 5);
        chk("t4_queue_empty", exp_q.size(), 0);

        // 5: driver never starts -> timeout retries then error
        nack11    = 1'b0;
        hang_mode = 1'b1;
        repeat (4) exp_q.push_back(16'h1280);
        base = pulses;
        pulse_start();
        wait_end(12000, "t5");
        chk("t5_error", error, 1);
        chk("t5_err_index", err_index, 0);
        chk("t5_done", done, 0);
        chk("t5_pulses", pulses - base, 4);
        chk("t5_retry_spacing_min", (wr_cyc[base + 1] - wr_cyc[base]) >= 1040, 1);
        chk("t5_retry_spacing_max", (wr_cyc[base + 1] - wr_cyc[base]) <= 1050, 1);
        chk("t5_queue_empty", exp_q.size(), 0);

        // 6: reset during WAIT_DONE
        hang_mode = 1'b0;
        exp_q.push_back(16'h1280);
        pulse_start();
        begin
            int n = 0;
            while (iic.iic_work_done && n < 4000) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (n >= 4000) begin
                failures++;
                $display("FAIL t6_wait_busy_timeout actual=%0d cycles required<4000", n);
            end
        end
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_wr_en", iic.iic_wr_en, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_state", dbg_state, ST_IDLE);
        chk("t6_rst_cfg_index", cfg_index, 0);
        @(negedge clk);
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1101);
        base = pulses;
        rel  = cyc;
        rst  = 1'b1;
        wait_end(6000, "t6");
        chk("t6_done", done, 1);
        chk("t6_pulses", pulses - base, 2);
        chk("t6_powerup_min", (wr_cyc[base] - rel) >= 2000, 1);
        chk("t6_queue_empty", exp_q.size(), 0);

        // start edge after done reruns the table
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1101);
        base = pulses;
        pulse_start();
        wait_end(6000, "t7");
        chk("t7_done", done, 1);
        chk("t7_error", error, 0);
        chk("t7_pulses", pulses - base, 2);
        chk("t7_queue_empty", exp_q.size(), 0);
        chk("t7_rd_en", iic.iic_rd_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
